narrow2wide_packer: RTL



---
 rtl/avs_pack_pkg.sv | 19 +
 rtl/narrow2wide_packer_if.sv | 21 ++
 rtl/narrow2wide_packer_out_reg.sv | 29 ++
 rtl/narrow2wide_packer.sv | 108 ++++++++++
 4 files changed

// File: rtl/avs_pack_pkg.sv
// Beat-order constants and slot placement shared by packer/unpacker.
// slot_lsb(): LSB position of beat <index> inside an in_w*ratio word.
package avs_pack_pkg;

  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  function automatic int slot_lsb(
    input int index,
    input int in_w,
    input int ratio,
    input bit order
  );
    if (order == ORDER_MSB_FIRST)
      return (ratio - 1 - index) * in_w;
    return index * in_w;
  endfunction

endpackage

// File: rtl/narrow2wide_packer_if.sv
// Valid/ready stream bundle of width W.
// master drives valid/data, slave drives ready.
interface narrow2wide_packer_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/narrow2wide_packer_out_reg.sv
// pack_out_reg: one-entry valid/ready output register.
// load replaces the entry even while it is being drained.
module pack_out_reg #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] dout
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        dout  <= din;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/narrow2wide_packer.sv
// Packs RATIO narrow IN_W beats into one IN_W*RATIO word.
// Ports: clock, reset, in_s (stream slave), out_m (stream master);
// with N2W_PACKER_FLUSH_EN also flush, out_partial, out_beats.
module narrow2wide_packer
  import avs_pack_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1,
  localparam int OUT_W    = IN_W * RATIO,
  localparam int BW       = $clog2(RATIO + 1)
) (
  input  logic clock,
  input  logic reset,
  narrow2wide_packer_if.slave  in_s,
  narrow2wide_packer_if.master out_m
`ifdef N2W_PACKER_FLUSH_EN
  ,
  input  logic          flush,
  output logic          out_partial,
  output logic [BW-1:0] out_beats
`endif
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
  localparam bit ORDER = (MSB_FIRST != 0) ? ORDER_MSB_FIRST
                                          : ORDER_LSB_FIRST;
`ifdef N2W_PACKER_FLUSH_EN
  localparam int SW = OUT_W + 1 + BW;
`else
  localparam int SW = OUT_W;
`endif

  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] merged;
  logic [SW-1:0]    word;
  logic [SW-1:0]    dout;
  logic last;
  logic slot_ok;
  logic hold;
  logic in_xfer;
  logic emit;

  assign last    = (cnt == LAST);
  assign slot_ok = !out_m.valid || out_m.ready;

`ifdef N2W_PACKER_FLUSH_EN
  // Flush closes a word early; it only stalls like a final beat
  // when there is something to emit.
  logic          fl_req;
  logic [BW-1:0] beats;
  assign fl_req = flush && (cnt != '0 || in_s.valid);
  assign hold   = last || fl_req;
  assign emit   = (last && in_xfer) || (fl_req && slot_ok);
  assign beats  = BW'(cnt) + BW'(in_xfer);
  assign word   = {beats != BW'(RATIO), beats, merged};
`else
  assign hold = last;
  assign emit = last && in_xfer;
  assign word = merged;
`endif

  assign in_s.ready = hold ? slot_ok : 1'b1;
  assign in_xfer    = in_s.valid && in_s.ready;

  always_comb begin
    merged = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (in_xfer && cnt == CW'(k))
        merged[slot_lsb(k, IN_W, RATIO, ORDER) +: IN_W] = in_s.data;
    end
  end

  // Accumulator restarts from zero so flushed words zero-fill.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (emit) begin
      cnt <= '0;
      acc <= '0;
    end else if (in_xfer) begin
      cnt <= cnt + CW'(1);
      acc <= merged;
    end
  end

  pack_out_reg #(
    .W(SW)
  ) u_out (
    .clock(clock),
    .reset(reset),
    .load (emit),
    .din  (word),
    .valid(out_m.valid),
    .ready(out_m.ready),
    .dout (dout)
  );

  assign out_m.data = dout[OUT_W-1:0];
`ifdef N2W_PACKER_FLUSH_EN
  assign out_beats   = dout[OUT_W +: BW];
  assign out_partial = dout[SW-1];
`endif

endmodule
